spi_slave_responder: RTL and testbench

SPI slave endpoint that answers the simple_spi master's sck_o/mosi_o and drives its miso_i. It oversamples the SPI pins on the system clock, deserialises MOSI bytes into a valid/ready receive port and serialises bytes from a valid/ready transmit port onto MISO. It serves as the DUT-side partner in system benches and as a reusable peripheral-side block.

---
 rtl/spi_slave_pkg.sv | 23 ++
 rtl/spi_slave_responder_if.sv | 42 ++++
 rtl/spi_sync_edge.sv | 51 +++++
 rtl/spi_slave_responder.sv | 216 +++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared constants and types for the SPI slave responder:
//               byte width, TX FIFO depth, FSM state type and the default
//               byte shifted out when no transmit data is available.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

  localparam int BYTE_W        = 8;
  localparam int TX_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [BYTE_W-1:0] DEFAULT_IDLE_BYTE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/spi_slave_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_responder_if
// Description : Bundles the SPI pins, the transmit/receive valid-ready
//               streams and the status pulses of the SPI slave responder.
// Ports       : none; signals are accessed through modports
//               slave  - view of the responder itself
//               master - view of the surrounding system / SPI master side
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_responder_if;
  import spi_slave_pkg::*;

  logic              sck_i;
  logic              mosi_i;
  logic              ss_n_i;
  logic              miso_o;
  logic              miso_oe_o;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overrun;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  sck_i, mosi_i, ss_n_i, tx_data, tx_valid, rx_ready,
    output miso_o, miso_oe_o, tx_ready, rx_data, rx_valid,
           rx_overrun, tx_underrun, busy
  );

  modport master (
    output sck_i, mosi_i, ss_n_i, tx_data, tx_valid, rx_ready,
    input  miso_o, miso_oe_o, tx_ready, rx_data, rx_valid,
           rx_overrun, tx_underrun, busy
  );

endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Two-flop synchroniser for an asynchronous pin, plus one
//               history flop giving single-cycle rise/fall pulses.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               din  - asynchronous input
//               sync - synchronised level
//               rise - one-cycle pulse on a synchronised 0->1 transition
//               fall - one-cycle pulse on a synchronised 1->0 transition
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  // Edges are suppressed until the chain holds only real samples, so a pin
  // already at its active level when reset releases is not seen as an edge.
  logic [2:0] r_fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
      r_fill <= 3'b000;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fill <= {r_fill[1:0], 1'b1};
    end
  end

  assign sync = r_sync;
  assign rise = r_fill[2] &  r_sync & ~r_prev;
  assign fall = r_fill[2] & ~r_sync &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_responder
// Description : SPI slave endpoint. Oversamples SCK/MOSI/SS_N on clk,
//               deserialises MOSI bytes (MSB first) into a valid/ready
//               receive port and serialises bytes from a valid/ready
//               transmit port onto MISO.
// Ports       : clk, rst        - system clock (>= 8x SCK), sync reset
//               bus (slave)     - SPI pins, tx/rx streams, status pulses
// Parameters  : CPOL, CPHA      - SPI mode
//               USE_SS          - 1: frame by ss_n_i, 0: always selected
//               TX_IDLE         - byte sent when no tx data is available
// Build macro : SPI_SLAVE_TX_FIFO_EN - 4-entry TX FIFO instead of a
//               single holding register
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter bit                CPOL    = 1'b0,
  parameter bit                CPHA    = 1'b0,
  parameter bit                USE_SS  = 1'b1,
  parameter logic [BYTE_W-1:0] TX_IDLE = DEFAULT_IDLE_BYTE
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_slave_responder_if.slave bus
);

  localparam logic [0:0] c_IDLE   = IDLE;
  localparam logic [0:0] c_ACTIVE = ACTIVE;

  // ---------------- pin synchronisers ----------------
  logic w_sck_sync, w_sck_rise, w_sck_fall;
  logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
  logic w_ss_sync, w_ss_rise, w_ss_fall;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sck (
    .clk(clk), .rst(rst), .din(bus.sck_i),
    .sync(w_sck_sync), .rise(w_sck_rise), .fall(w_sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(bus.mosi_i),
    .sync(w_mosi_sync), .rise(w_mosi_rise), .fall(w_mosi_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .din(bus.ss_n_i),
    .sync(w_ss_sync), .rise(w_ss_rise), .fall(w_ss_fall)
  );

  logic w_unused;
  assign w_unused = ^{w_sck_sync, w_mosi_rise, w_mosi_fall, w_ss_sync};

  // ---------------- state ----------------
  logic [0:0]        r_state;
  logic [2:0]        r_bit_cnt;
  logic [BYTE_W-1:0] r_rx_sh;
  logic [BYTE_W-1:0] r_tx_sh;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_overrun;
  logic              r_tx_underrun;

  // ---------------- edge decode ----------------
  logic w_lead, w_trail, w_sample_edge, w_shift_edge;
  logic w_active, w_enter, w_leave, w_do_sample, w_do_shift;
  logic w_load, w_shift;

  assign w_lead        = CPOL ? w_sck_fall : w_sck_rise;
  assign w_trail       = CPOL ? w_sck_rise : w_sck_fall;
  assign w_sample_edge = CPHA ? w_trail : w_lead;
  assign w_shift_edge  = CPHA ? w_lead  : w_trail;

  assign w_active    = (r_state == c_ACTIVE);
  assign w_enter     = (r_state == c_IDLE) && (USE_SS ? w_ss_fall : 1'b1);
  assign w_leave     = w_active && USE_SS && w_ss_rise;
  assign w_do_sample = w_active && !w_leave && w_sample_edge;
  assign w_do_shift  = w_active && !w_leave && w_shift_edge;

  // In CPHA=0 the first byte must already be on MISO before the first SCK
  // edge, so it is loaded on selection; later bytes load on the shift edge
  // that follows a completed byte (bit_cnt already wrapped to 0).
  assign w_load  = CPHA ? (w_do_shift && (r_bit_cnt == 3'd0))
                        : (w_enter || (w_do_shift && (r_bit_cnt == 3'd0)));
  assign w_shift = w_do_shift && !w_load;

  // ---------------- transmit source ----------------
  logic              w_tx_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_src_avail;
  logic [BYTE_W-1:0] w_src_data;

  assign w_push = bus.tx_valid && w_tx_ready;
  assign w_pop  = w_load && w_src_avail;

`ifdef SPI_SLAVE_TX_FIFO_EN
  logic [BYTE_W-1:0] r_fifo [TX_FIFO_DEPTH];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_count;

  assign w_tx_ready  = (r_count < 3'(TX_FIFO_DEPTH));
  assign w_src_avail = (r_count != 3'd0);
  assign w_src_data  = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TX_FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.tx_data;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic              r_hold_full;
  logic [BYTE_W-1:0] r_hold_data;

  assign w_tx_ready  = !r_hold_full;
  assign w_src_avail = r_hold_full;
  assign w_src_data  = r_hold_data;

  // Push requires an empty register and pop a full one, so they never
  // coincide; a push during a load lands here and goes out next byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_push) begin
      r_hold_full <= 1'b1;
      r_hold_data <= bus.tx_data;
    end else if (w_pop) begin
      r_hold_full <= 1'b0;
    end
  end
`endif

  // ---------------- main datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_bit_cnt     <= 3'd0;
      r_rx_sh       <= '0;
      r_tx_sh       <= '1;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= w_load && !w_src_avail;

      if (w_enter) begin
        r_state <= c_ACTIVE;
      end else if (w_leave) begin
        r_state   <= c_IDLE;
        r_bit_cnt <= 3'd0;
        r_rx_sh   <= '0;
      end

      if (w_load) begin
        r_tx_sh <= w_src_avail ? w_src_data : TX_IDLE;
      end else if (w_shift) begin
        r_tx_sh <= {r_tx_sh[BYTE_W-2:0], 1'b1};
      end

      if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      // A byte completing in the same cycle as a handshake overrides the
      // clear above, keeping rx_valid high with the new data.
      if (w_do_sample) begin
        r_rx_sh   <= {r_rx_sh[BYTE_W-2:0], w_mosi_sync};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          if (!r_rx_valid || bus.rx_ready) begin
            r_rx_data  <= {r_rx_sh[BYTE_W-2:0], w_mosi_sync};
            r_rx_valid <= 1'b1;
          end else begin
            r_rx_overrun <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.miso_o      = r_tx_sh[BYTE_W-1];
  assign bus.miso_oe_o   = w_active;
  assign bus.tx_ready    = w_tx_ready;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.rx_overrun  = r_rx_overrun;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.busy        = w_active && (r_bit_cnt != 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_responder
// Description : Self-checking bench for spi_slave_responder. Two instances
//               are exercised: index 0 in mode 0 (CPOL=0, CPHA=0) and
//               index 1 in mode 3 (CPOL=1, CPHA=1). A byte-level model of
//               the transmit queue predicts MISO bytes and underruns.
// Build macro : SPI_SLAVE_TX_FIFO_EN - selects the FIFO scenario/depth
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_responder;

`ifdef SPI_SLAVE_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_responder_if if0 ();
  spi_slave_responder_if if1 ();

  spi_slave_responder #(.CPOL(1'b0), .CPHA(1'b0), .USE_SS(1'b1), .TX_IDLE(8'hFF)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  spi_slave_responder #(.CPOL(1'b1), .CPHA(1'b1), .USE_SS(1'b1), .TX_IDLE(8'hFF)) dut3 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  // Bench-side drive and observe arrays, index = instance.
  logic       sck_d [2];
  logic       ss_d  [2];
  logic       txv_d [2];
  logic       rxr_d [2];
  logic [7:0] txd_d [2];
  logic       mosi_d;

  logic       miso_w [2];
  logic       oe_w   [2];
  logic       txr_w  [2];
  logic       rxv_w  [2];
  logic       ovr_w  [2];
  logic       und_w  [2];
  logic       busy_w [2];
  logic [7:0] rxd_w  [2];

  assign if0.sck_i = sck_d[0];  assign if1.sck_i = sck_d[1];
  assign if0.ss_n_i = ss_d[0];  assign if1.ss_n_i = ss_d[1];
  assign if0.mosi_i = mosi_d;   assign if1.mosi_i = mosi_d;
  assign if0.tx_valid = txv_d[0]; assign if1.tx_valid = txv_d[1];
  assign if0.tx_data = txd_d[0];  assign if1.tx_data = txd_d[1];
  assign if0.rx_ready = rxr_d[0]; assign if1.rx_ready = rxr_d[1];

  assign miso_w[0] = if0.miso_o;      assign miso_w[1] = if1.miso_o;
  assign oe_w[0]   = if0.miso_oe_o;   assign oe_w[1]   = if1.miso_oe_o;
  assign txr_w[0]  = if0.tx_ready;    assign txr_w[1]  = if1.tx_ready;
  assign rxv_w[0]  = if0.rx_valid;    assign rxv_w[1]  = if1.rx_valid;
  assign ovr_w[0]  = if0.rx_overrun;  assign ovr_w[1]  = if1.rx_overrun;
  assign und_w[0]  = if0.tx_underrun; assign und_w[1]  = if1.tx_underrun;
  assign busy_w[0] = if0.busy;        assign busy_w[1] = if1.busy;
  assign rxd_w[0]  = if0.rx_data;     assign rxd_w[1]  = if1.rx_data;

  int n_vec = 0;
  int n_err = 0;

  // Observed event counters and accepted-byte history.
  int         und_cnt [2];
  int         ovr_cnt [2];
  int         rx_cnt  [2];
  logic [7:0] rx_hist [2][64];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (und_w[i] === 1'b1) und_cnt[i]++;
      if (ovr_w[i] === 1'b1) ovr_cnt[i]++;
      if (rxv_w[i] === 1'b1 && rxr_d[i] === 1'b1) begin
        rx_hist[i][rx_cnt[i] % 64] = rxd_w[i];
        rx_cnt[i]++;
      end
    end
  end

  // Reference model: an ordered queue of written bytes per instance.
  logic [7:0] mq [2][4];
  int         mq_n    [2];
  int         exp_und [2];

  logic [7:0] frame_tx [8];
  logic [7:0] frame_rx [8];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_load(input int sel, output logic [7:0] b);
    if (mq_n[sel] > 0) begin
      b = mq[sel][0];
      for (int k = 0; k < 3; k++) mq[sel][k] = mq[sel][k+1];
      mq_n[sel]--;
    end else begin
      b = 8'hFF;
      exp_und[sel]++;
    end
  endtask

  task automatic push_tx(input int sel, input logic [7:0] d);
    txd_d[sel] = d;
    txv_d[sel] = 1'b1;
    wait_clk(1);
    txv_d[sel] = 1'b0;
    mq[sel][mq_n[sel]] = d;
    mq_n[sel]++;
  endtask

  // Master shifting nbits of mo (MSB first), capturing MISO at its sample edge.
  task automatic spi_bits(input int sel, input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (sel == 0) begin
        mosi_d = mo[i];
        wait_clk(8);
        sck_d[0] = 1'b1;
        mi[i] = miso_w[0];
        wait_clk(8);
        sck_d[0] = 1'b0;
      end else begin
        sck_d[1] = 1'b0;
        mosi_d = mo[i];
        wait_clk(8);
        sck_d[1] = 1'b1;
        mi[i] = miso_w[1];
        wait_clk(8);
      end
    end
  endtask

  task automatic select_dev(input int sel);
    ss_d[sel] = 1'b0;
    wait_clk(8);
  endtask

  task automatic deselect_dev(input int sel);
    wait_clk(8);
    ss_d[sel] = 1'b1;
    wait_clk(8);
  endtask

  // Full frame of n bytes with rx_ready high; scored against the model.
  // Mode 0 loads one extra byte on the trailing edge after the last bit.
  task automatic run_scored_frame(input int sel, input int n);
    logic [7:0] exp_rd [8];
    logic [7:0] b;
    int rc0;
    int loads;
    loads = n + ((sel == 0) ? 1 : 0);
    for (int k = 0; k < loads; k++) begin
      model_load(sel, b);
      if (k < n) exp_rd[k] = b;
    end
    rc0 = rx_cnt[sel];
    select_dev(sel);
    for (int k = 0; k < n; k++) spi_bits(sel, frame_tx[k], 8, frame_rx[k]);
    deselect_dev(sel);
    for (int k = 0; k < n; k++) begin
      n_vec++;
      if (frame_rx[k] !== exp_rd[k]) begin
        n_err++;
        $display("FAIL miso_byte dev%0d byte%0d got %h exp %h", sel, k, frame_rx[k], exp_rd[k]);
      end
      n_vec++;
      if (rx_hist[sel][(rc0 + k) % 64] !== frame_tx[k]) begin
        n_err++;
        $display("FAIL rx_byte dev%0d byte%0d got %h exp %h", sel, k,
                 rx_hist[sel][(rc0 + k) % 64], frame_tx[k]);
      end
    end
    n_vec++;
    if (rx_cnt[sel] - rc0 !== n) begin
      n_err++;
      $display("FAIL rx_count dev%0d got %0d exp %0d", sel, rx_cnt[sel] - rc0, n);
    end
    n_vec++;
    if (und_cnt[sel] !== exp_und[sel]) begin
      n_err++;
      $display("FAIL underrun_count dev%0d got %0d exp %0d", sel, und_cnt[sel], exp_und[sel]);
    end
    n_vec++;
    if (txr_w[sel] !== (mq_n[sel] < DEPTH)) begin
      n_err++;
      $display("FAIL tx_ready dev%0d got %b exp %b", sel, txr_w[sel], (mq_n[sel] < DEPTH));
    end
    n_vec++;
    if (oe_w[sel] !== 1'b0 || busy_w[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL deselected dev%0d oe %b busy %b exp 0 0", sel, oe_w[sel], busy_w[sel]);
    end
  endtask

  task automatic test_reset();
    wait_clk(4);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({miso_w[i], oe_w[i], txr_w[i], rxv_w[i]} !== 4'b1010) begin
        n_err++;
        $display("FAIL reset_ctrl dev%0d got miso/oe/txr/rxv %b%b%b%b exp 1010",
                 i, miso_w[i], oe_w[i], txr_w[i], rxv_w[i]);
      end
      n_vec++;
      if (rxd_w[i] !== 8'h00) begin
        n_err++;
        $display("FAIL reset_rx_data dev%0d got %h exp 00", i, rxd_w[i]);
      end
      n_vec++;
      if ({ovr_w[i], und_w[i], busy_w[i]} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_status dev%0d got ovr/und/busy %b%b%b exp 000",
                 i, ovr_w[i], und_w[i], busy_w[i]);
      end
    end
    rst = 1'b0;
    wait_clk(6);
  endtask

  task automatic test_mode0();
    push_tx(0, 8'h3C);
    n_vec++;
    if (txr_w[0] !== (mq_n[0] < DEPTH)) begin
      n_err++;
      $display("FAIL mode0_tx_ready_full got %b exp %b", txr_w[0], (mq_n[0] < DEPTH));
    end
    frame_tx[0] = 8'hA5;
    run_scored_frame(0, 1);
  endtask

  task automatic test_mode3();
    push_tx(1, 8'hC3);
    frame_tx[0] = 8'h5A;
    run_scored_frame(1, 1);
  endtask

  task automatic test_underrun();
    int u0;
    u0 = und_cnt[1];
    frame_tx[0] = 8'h00;
    run_scored_frame(1, 1);
    n_vec++;
    if (und_cnt[1] - u0 !== 1) begin
      n_err++;
      $display("FAIL underrun_pulses got %0d exp 1", und_cnt[1] - u0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] b, mi;
    int rc0, o0;
    rxr_d[0] = 1'b0;
    rc0 = rx_cnt[0];
    o0  = ovr_cnt[0];
    for (int k = 0; k < 3; k++) model_load(0, b);
    select_dev(0);
    spi_bits(0, 8'h11, 8, mi);
    spi_bits(0, 8'h22, 8, mi);
    deselect_dev(0);
    n_vec++;
    if (rxv_w[0] !== 1'b1 || rxd_w[0] !== 8'h11) begin
      n_err++;
      $display("FAIL overrun_hold got valid %b data %h exp 1 11", rxv_w[0], rxd_w[0]);
    end
    n_vec++;
    if (ovr_cnt[0] - o0 !== 1) begin
      n_err++;
      $display("FAIL overrun_pulses got %0d exp 1", ovr_cnt[0] - o0);
    end
    n_vec++;
    if (und_cnt[0] !== exp_und[0]) begin
      n_err++;
      $display("FAIL overrun_underrun_count got %0d exp %0d", und_cnt[0], exp_und[0]);
    end
    rxr_d[0] = 1'b1;
    wait_clk(3);
    n_vec++;
    if (rx_cnt[0] - rc0 !== 1 || rx_hist[0][rc0 % 64] !== 8'h11 || rxv_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_drain got count %0d byte %h valid %b exp 1 11 0",
               rx_cnt[0] - rc0, rx_hist[0][rc0 % 64], rxv_w[0]);
    end
    frame_tx[0] = 8'h33;
    run_scored_frame(0, 1);
  endtask

  task automatic test_partial();
    logic [7:0] b, mi;
    int rc0;
    rc0 = rx_cnt[0];
    model_load(0, b);
    select_dev(0);
    spi_bits(0, 8'hE0, 3, mi);
    n_vec++;
    if (busy_w[0] !== 1'b1 || oe_w[0] !== 1'b1) begin
      n_err++;
      $display("FAIL partial_mid got busy %b oe %b exp 1 1", busy_w[0], oe_w[0]);
    end
    n_vec++;
    if (mi[7:5] !== b[7:5]) begin
      n_err++;
      $display("FAIL partial_miso got %b exp %b", mi[7:5], b[7:5]);
    end
    deselect_dev(0);
    n_vec++;
    if (oe_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || rx_cnt[0] !== rc0) begin
      n_err++;
      $display("FAIL partial_drop got oe %b busy %b rx %0d exp 0 0 %0d",
               oe_w[0], busy_w[0], rx_cnt[0], rc0);
    end
    frame_tx[0] = 8'h96;
    run_scored_frame(0, 1);
  endtask

`ifdef SPI_SLAVE_TX_FIFO_EN
  task automatic test_fifo();
    for (int k = 1; k <= 4; k++) begin
      n_vec++;
      if (txr_w[1] !== 1'b1) begin
        n_err++;
        $display("FAIL fifo_ready_before_push%0d got %b exp 1", k, txr_w[1]);
      end
      push_tx(1, 8'(k));
    end
    n_vec++;
    if (txr_w[1] !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_ready_full got %b exp 0", txr_w[1]);
    end
    for (int k = 0; k < 5; k++) frame_tx[k] = 8'($urandom);
    run_scored_frame(1, 5);
    n_vec++;
    if (frame_rx[4] !== 8'hFF) begin
      n_err++;
      $display("FAIL fifo_fifth_byte got %h exp ff", frame_rx[4]);
    end
  endtask
`endif

  task automatic test_random();
    int sel, nb, np;
    for (int it = 0; it < 12; it++) begin
      sel = $urandom_range(0, 1);
      nb  = $urandom_range(1, 3);
      np  = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        if (mq_n[sel] < DEPTH) begin
          n_vec++;
          if (txr_w[sel] !== 1'b1) begin
            n_err++;
            $display("FAIL random_tx_ready dev%0d got %b exp 1", sel, txr_w[sel]);
          end
          push_tx(sel, 8'($urandom));
        end
      end
      for (int k = 0; k < nb; k++) frame_tx[k] = 8'($urandom);
      run_scored_frame(sel, nb);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      sck_d[i] = (i == 1);
      ss_d[i]  = 1'b1;
      txv_d[i] = 1'b0;
      rxr_d[i] = 1'b1;
      txd_d[i] = 8'h00;
      mq_n[i] = 0;
      exp_und[i] = 0;
      und_cnt[i] = 0;
      ovr_cnt[i] = 0;
      rx_cnt[i] = 0;
    end
    mosi_d = 1'b0;
    test_reset();
    test_mode0();
    test_mode3();
    test_underrun();
`ifdef SPI_SLAVE_TX_FIFO_EN
    test_fifo();
`endif
    test_overrun();
    test_partial();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
